// File: rtl/coef_sequencer.sv
// rtl/coef_sequencer.sv - tap-indexed multi-channel coefficient sequencer with latency-matched valid/last
//
// Pairs each accepted sample with a tap index and presents one coefficient per
// channel for that tap, read from runtime-writable banks. The output stage is a
// single register slice with backpressure. A fixed-depth delay line replays the
// output handshake (and frame-last) to line up with downstream multipliers.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   tdata_in/tvalid_in/tlast_in      sample stream in
//   tready_out                       sample stream ready
//   tap_clr                          synchronous tap-index clear
//   coef_wr_en/_ch/_idx/_data        coefficient write port
//   out_ready                        downstream ready
//   out_valid                        output register holds valid data
//   data_to_mult_a                   registered sample
//   data_to_mult_b                   coefficients, channel k at [k*COEF_W +: COEF_W]
//   tap_idx_out/tap_last_out         tap index of presented sample, last-tap flag
//   frame_last_out                   registered tlast_in
//   mult_valid/mult_last             handshake / frame-last delayed by PIPE_LAT cycles
module coef_sequencer #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 12,
    parameter int NUM_CH   = 13,
    parameter int NUM_TAPS = 15,
    parameter int PIPE_LAT = 4,
    localparam int IDX_W   = $clog2(NUM_TAPS),
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          tdata_in,
    input  logic                       tvalid_in,
    input  logic                       tlast_in,
    output logic                       tready_out,
    input  logic                       tap_clr,
    input  logic                       coef_wr_en,
    input  logic [CH_W-1:0]            coef_wr_ch,
    input  logic [IDX_W-1:0]           coef_wr_idx,
    input  logic [COEF_W-1:0]          coef_wr_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          data_to_mult_a,
    output logic [NUM_CH*COEF_W-1:0]   data_to_mult_b,
    output logic [IDX_W-1:0]           tap_idx_out,
    output logic                       tap_last_out,
    output logic                       frame_last_out,
    output logic                       mult_valid,
    output logic                       mult_last
);

    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

    // Coefficient banks: deliberately not reset so they map onto plain RAM.
    logic [COEF_W-1:0] coef_mem [NUM_CH][NUM_TAPS];

    logic [IDX_W-1:0]         tap_q, tap_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        data_a_q, data_a_d;
    logic [NUM_CH*COEF_W-1:0] data_b_q, data_b_d;
    logic [IDX_W-1:0]         tap_idx_q, tap_idx_d;
    logic                     tap_last_q, tap_last_d;
    logic                     frame_last_q, frame_last_d;
    logic [PIPE_LAT-1:0]      vld_pipe_q, vld_pipe_d;
    logic [PIPE_LAT-1:0]      last_pipe_q, last_pipe_d;

    logic                     in_fire;
    logic                     out_fire;
    logic                     tap_is_last;
    logic [NUM_CH*COEF_W-1:0] coef_row;

    // Out-of-range channel/index writes are dropped entirely.
    always_ff @(posedge clk) begin
        if (coef_wr_en && (int'(coef_wr_ch) < NUM_CH) && (int'(coef_wr_idx) < NUM_TAPS)) begin
            coef_mem[coef_wr_ch][coef_wr_idx] <= coef_wr_data;
        end
    end

    // Asynchronous read of the current tap across all channels; capturing it into
    // the output register on the same edge as a write gives read-first behaviour.
    always_comb begin
        coef_row = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            coef_row[k*COEF_W +: COEF_W] = coef_mem[k][tap_q];
        end
    end

    assign tready_out  = !out_valid_q || out_ready;
    assign in_fire     = tvalid_in && tready_out;
    assign out_fire    = out_valid_q && out_ready;
    assign tap_is_last = (tap_q == LAST_TAP);

    always_comb begin
        out_valid_d  = out_valid_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        tap_idx_d    = tap_idx_q;
        tap_last_d   = tap_last_q;
        frame_last_d = frame_last_q;
        tap_d        = tap_q;
        vld_pipe_d   = '0;
        last_pipe_d  = '0;

        if (in_fire) begin
            out_valid_d  = 1'b1;
            data_a_d     = tdata_in;
            data_b_d     = coef_row;
            tap_idx_d    = tap_q;
            tap_last_d   = tap_is_last;
            frame_last_d = tlast_in;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // The sample firing alongside tap_clr has already latched the old index above.
        if (tap_clr) begin
            tap_d = '0;
        end else if (in_fire) begin
            if (tlast_in || tap_is_last) begin
                tap_d = '0;
            end else begin
                tap_d = tap_q + IDX_W'(1);
            end
        end

        // Free-running shift: downstream multipliers do not stall.
        vld_pipe_d[0]  = out_fire;
        last_pipe_d[0] = out_fire && frame_last_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q        <= '0;
            out_valid_q  <= 1'b0;
            data_a_q     <= '0;
            data_b_q     <= '0;
            tap_idx_q    <= '0;
            tap_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            vld_pipe_q   <= '0;
            last_pipe_q  <= '0;
        end else begin
            tap_q        <= tap_d;
            out_valid_q  <= out_valid_d;
            data_a_q     <= data_a_d;
            data_b_q     <= data_b_d;
            tap_idx_q    <= tap_idx_d;
            tap_last_q   <= tap_last_d;
            frame_last_q <= frame_last_d;
            vld_pipe_q   <= vld_pipe_d;
            last_pipe_q  <= last_pipe_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign data_to_mult_a = data_a_q;
    assign data_to_mult_b = data_b_q;
    assign tap_idx_out    = tap_idx_q;
    assign tap_last_out   = tap_last_q;
    assign frame_last_out = frame_last_q;
    assign mult_valid     = vld_pipe_q[PIPE_LAT-1];
    assign mult_last      = last_pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_coef_sequencer.sv
// tb/tb_coef_sequencer.sv - randomized scoreboard bench for coef_sequencer
module tb_coef_sequencer;

    localparam int DATA_W   = 16;
    localparam int COEF_W   = 12;
    localparam int NUM_CH   = 13;
    localparam int NUM_TAPS = 15;
    localparam int PIPE_LAT = 4;
    localparam int IDX_W    = $clog2(NUM_TAPS);
    localparam int CH_W     = $clog2(NUM_CH);
    localparam int B_W      = NUM_CH * COEF_W;
    localparam int MAXC     = 64;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] tdata_in;
    logic              tvalid_in;
    logic              tlast_in;
    logic              tready_out;
    logic              tap_clr;
    logic              coef_wr_en;
    logic [CH_W-1:0]   coef_wr_ch;
    logic [IDX_W-1:0]  coef_wr_idx;
    logic [COEF_W-1:0] coef_wr_data;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] data_to_mult_a;
    logic [B_W-1:0]    data_to_mult_b;
    logic [IDX_W-1:0]  tap_idx_out;
    logic              tap_last_out;
    logic              frame_last_out;
    logic              mult_valid;
    logic              mult_last;

    coef_sequencer #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_CH(NUM_CH),
        .NUM_TAPS(NUM_TAPS), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tdata_in(tdata_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in), .tready_out(tready_out),
        .tap_clr(tap_clr),
        .coef_wr_en(coef_wr_en), .coef_wr_ch(coef_wr_ch), .coef_wr_idx(coef_wr_idx),
        .coef_wr_data(coef_wr_data),
        .out_ready(out_ready), .out_valid(out_valid),
        .data_to_mult_a(data_to_mult_a), .data_to_mult_b(data_to_mult_b),
        .tap_idx_out(tap_idx_out), .tap_last_out(tap_last_out), .frame_last_out(frame_last_out),
        .mult_valid(mult_valid), .mult_last(mult_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending samples in a queue, coefficient table, tap counter
    // and a per-cycle record of output handshakes for the delayed pulses.
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              tl;
        logic              fl;
        logic [B_W-1:0]    b;
    } ent_t;

    ent_t              q[$];
    ent_t              cur;
    logic [COEF_W-1:0] m_coef [NUM_CH][NUM_TAPS];
    int                m_tap;
    int                cyc = MAXC;
    bit                fire_at  [MAXC];
    bit                lfire_at [MAXC];
    bit                m_in_fire;
    int                hs_cnt;

    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic r,
                        input logic clr, input logic we, input logic [CH_W-1:0] wc,
                        input logic [IDX_W-1:0] wi, input logic [COEF_W-1:0] wd);
        bit   exp_rdy;
        bit   ofire;
        ent_t e;
        @(negedge clk);
        tvalid_in = v; tdata_in = d; tlast_in = l; out_ready = r; tap_clr = clr;
        coef_wr_en = we; coef_wr_ch = wc; coef_wr_idx = wi; coef_wr_data = wd;
        #1;
        chk("out_valid", out_valid, q.size() != 0);
        chk("data_a", data_to_mult_a, cur.data);
        chk("data_b", data_to_mult_b, cur.b);
        chk("tap_idx", tap_idx_out, cur.idx);
        chk("tap_last", tap_last_out, cur.tl);
        chk("frame_last", frame_last_out, cur.fl);
        chk("mult_valid", mult_valid, fire_at[(cyc - PIPE_LAT) % MAXC]);
        chk("mult_last", mult_last, lfire_at[(cyc - PIPE_LAT) % MAXC]);
        exp_rdy = (q.size() == 0) || r;
        chk("tready", tready_out, exp_rdy);
        if (out_valid && r) hs_cnt++;

        ofire     = (q.size() != 0) && r;
        m_in_fire = v && exp_rdy;
        fire_at[cyc % MAXC]  = ofire;
        lfire_at[cyc % MAXC] = ofire ? q[0].fl : 1'b0;
        if (ofire) void'(q.pop_front());
        if (m_in_fire) begin
            e.data = d;
            e.idx  = IDX_W'(m_tap);
            e.tl   = (m_tap == NUM_TAPS - 1);
            e.fl   = l;
            for (int k = 0; k < NUM_CH; k++) e.b[k*COEF_W +: COEF_W] = m_coef[k][m_tap];
            q.push_back(e);
            cur = e;
        end
        if (we && int'(wc) < NUM_CH && int'(wi) < NUM_TAPS) m_coef[wc][wi] = wd;
        if (clr) m_tap = 0;
        else if (m_in_fire) m_tap = l ? 0 : (m_tap + 1) % NUM_TAPS;
        cyc++;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, r, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic clear_tap();
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic send(input int n, input int base, input int last_at);
        for (int i = 0; i < n; i++)
            step(1'b1, DATA_W'(base + i), (i == last_at), 1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Observe outputs loaded by the edge that follows the most recent step.
    task automatic peek(input string tag, input logic [255:0] got_sel, input logic [255:0] exp);
        chk(tag, got_sel, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        tvalid_in = 0; tdata_in = '0; tlast_in = 0; out_ready = 0; tap_clr = 0;
        coef_wr_en = 0; coef_wr_ch = '0; coef_wr_idx = '0; coef_wr_data = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_a", data_to_mult_a, 0);
        chk("rst_data_b", data_to_mult_b, 0);
        chk("rst_tap_idx", tap_idx_out, 0);
        chk("rst_tap_last", tap_last_out, 0);
        chk("rst_frame_last", frame_last_out, 0);
        chk("rst_mult_valid", mult_valid, 0);
        chk("rst_mult_last", mult_last, 0);
        q.delete();
        cur = '{default: '0};
        m_tap = 0;
        for (int i = 0; i < MAXC; i++) begin
            fire_at[i]  = 1'b0;
            lfire_at[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int sent;
        int guard;

        rst_n = 1'b0;
        do_reset();

        // Load coef[ch][i] = ch*16 + i.
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int i = 0; i < NUM_TAPS; i++)
                step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, CH_W'(ch), IDX_W'(i), COEF_W'(ch * 16 + i));

        // Two full tap cycles at full throughput.
        send(30, 16'h0100, -1);
        @(posedge clk); #2;
        peek("tap_last_s29", tap_last_out, 1);
        peek("ch3_s29", data_to_mult_b[3*COEF_W +: COEF_W], 12'h03E);
        idle(PIPE_LAT + 1, 1'b1);

        // Frame end on the 5th sample restarts the tap index.
        clear_tap();
        send(6, 16'h0180, 4);
        @(posedge clk); #2;
        peek("idx_after_tlast", tap_idx_out, 0);
        idle(PIPE_LAT + 1, 1'b1);

        // Stalls: out_ready 1,0,0,1 with continuous valid.
        idle(1, 1'b1);
        hs_cnt = 0;
        sent = 0;
        guard = 0;
        while (sent < 20 && guard < 200) begin
            step(1'b1, DATA_W'(16'h0200 + sent), 1'b0, pat[guard % 4], 1'b0, 1'b0, '0, '0, '0);
            if (m_in_fire) sent++;
            guard++;
        end
        chk("stall_sent", sent, 20);
        idle(2, 1'b1);
        chk("stall_handshakes", hs_cnt, 20);
        idle(PIPE_LAT, 1'b1);

        // Write collides with a tap-3 fire: old value out now, new value next frame.
        clear_tap();
        for (int i = 0; i < 19; i++) begin
            step(1'b1, DATA_W'(16'h0300 + i), 1'b0, 1'b1, 1'b0, (i == 3), CH_W'(2), IDX_W'(3), 12'hABC);
            if (i == 3) begin
                @(posedge clk); #2;
                peek("coef_old", data_to_mult_b[2*COEF_W +: COEF_W], 12'h023);
            end
        end
        @(posedge clk); #2;
        peek("coef_new", data_to_mult_b[2*COEF_W +: COEF_W], 12'hABC);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, CH_W'(NUM_CH), IDX_W'(3), 12'h555);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, CH_W'(2), IDX_W'(NUM_TAPS), 12'h555);
        clear_tap();
        send(4, 16'h0340, -1);
        @(posedge clk); #2;
        peek("coef_kept", data_to_mult_b[2*COEF_W +: COEF_W], 12'hABC);
        idle(PIPE_LAT + 1, 1'b1);

        // tap_clr together with a fire at tap 7.
        clear_tap();
        send(7, 16'h0400, -1);
        step(1'b1, 16'h0407, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, '0);
        @(posedge clk); #2;
        peek("clr_same_idx", tap_idx_out, 7);
        step(1'b1, 16'h0408, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #2;
        peek("clr_next_idx", tap_idx_out, 0);
        idle(PIPE_LAT + 1, 1'b1);

        // Randomized traffic, writes (some out of range), clears and frame ends.
        for (int n = 0; n < 1200; n++)
            step(1'($urandom_range(0, 1)), DATA_W'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0), CH_W'($urandom_range(0, 15)),
                 IDX_W'($urandom_range(0, 15)), COEF_W'($urandom));

        // Reset mid-stream with output valid and pulses pending.
        send(3, 16'h0500, -1);
        do_reset();
        send(5, 16'h0600, -1);
        idle(PIPE_LAT + 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
